fir_peak_finder: RTL and testbench

Downstream consumer of `fir_trig`. Takes the four filtered lanes (`fout_0..3`) and the per-lane time-over-threshold bits, and delimits each trigger window. For each window it reports the peak filtered amplitude, the sample timestamp of the peak, the window length and a timeout flag. Results go out through a one-deep valid/ready register. It sits beside `Q_extractor` and is fed by the same `fir_trig` outputs.

---
 rtl/fir_peak_finder.sv | 250 +++++++++++++++++++++++++
 tb/tb_fir_peak_finder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_peak_finder.sv
// -----------------------------------------------------------------------------
// fir_peak_finder
//
// Sits downstream of fir_trig. Each trigger window runs while any lane's
// time-over-threshold bit is set. For every window the block reports the peak
// filtered amplitude, the timestamp of that peak ({cycle_cnt, lane}), the
// window length in valid cycles and whether MAX_TRIG_LEN forced the close.
// Results leave through a one-deep valid/ready output register.
//
// Parameters:
//   MAX_TRIG_LEN : valid cycles before a window is force-closed (1..65535)
//   HOLDOFF      : valid cycles ignored after a window closes (0 allowed)
//   TIME_W       : timestamp width; the low 2 bits carry the lane index
//
// Ports:
//   clk            : clock
//   reset_n        : asynchronous active-low reset
//   valid_in       : lane data valid (fir_trig fvalid_out)
//   fout_0..fout_3 : filtered samples, unsigned, lane 0 earliest
//   tot_0..tot_3   : per-lane time-over-threshold bits
//   valid_out      : result register holds an unconsumed result
//   ready_in       : consumer accepts the result
//   peak           : maximum sample in the window
//   peak_time      : {cycle_cnt, lane} of the peak
//   trig_len       : window length in valid cycles
//   timeout        : window was closed by MAX_TRIG_LEN
//   drop_count     : saturating count of discarded results
//
// Build option:
//   FIR_PEAK_FINDER_DROP_CNT_EN : when defined, drop_count counts discarded
//   results; when undefined, drop_count is tied to 0. Discarding itself
//   behaves identically either way.
// -----------------------------------------------------------------------------
module fir_peak_finder #(
  parameter int MAX_TRIG_LEN = 64,
  parameter int HOLDOFF      = 4,
  parameter int TIME_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [30:0]       fout_0,
  input  logic [30:0]       fout_1,
  input  logic [30:0]       fout_2,
  input  logic [30:0]       fout_3,
  input  logic              tot_0,
  input  logic              tot_1,
  input  logic              tot_2,
  input  logic              tot_3,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [30:0]       peak,
  output logic [TIME_W-1:0] peak_time,
  output logic [15:0]       trig_len,
  output logic              timeout,
  output logic [7:0]        drop_count
);

  localparam int CNT_W  = TIME_W - 2;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [15:0]       MAX_LEN   = 16'(MAX_TRIG_LEN);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HOLD,
    S_WAIT_LOW
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [15:0]         len_q, len_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [30:0]         max_q, max_d;
  logic [TIME_W-1:0]   time_q, time_d;

  logic                any_tot;
  logic [30:0]         lanes [4];
  logic [30:0]         fold_val;
  logic [TIME_W-1:0]   fold_time;

  logic                close;
  logic                close_timeout;
  logic [15:0]         close_len;
  logic [30:0]         close_peak;
  logic [TIME_W-1:0]   close_time;

  assign any_tot  = tot_0 | tot_1 | tot_2 | tot_3;
  assign lanes[0] = fout_0;
  assign lanes[1] = fout_1;
  assign lanes[2] = fout_2;
  assign lanes[3] = fout_3;

  // Fold this cycle's four lanes into the running max. In IDLE the window is
  // being opened, so lane 0 seeds the compare instead of the stale max.
  // Strictly-greater replacement walking lanes 0..3 keeps the earliest sample
  // on ties, both across cycles and within a cycle.
  always_comb begin
    // NOTE: blocking assignments inside always_comb let the loop chain each
    // lane's compare onto the previous result within a single cycle.
    if (state_q == S_ACTIVE) begin
      fold_val  = max_q;
      fold_time = time_q;
    end else begin
      fold_val  = lanes[0];
      fold_time = {cycle_cnt, 2'd0};
    end
    for (int i = 1 - ((state_q == S_ACTIVE) ? 1 : 0); i < 4; i++) begin
      if (lanes[i] > fold_val) begin
        fold_val  = lanes[i];
        fold_time = {cycle_cnt, 2'(i)};
      end
    end
  end

  // Next-state and close-event decode. Nothing moves unless valid_in is high.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d       = state_q;
    len_d         = len_q;
    hold_d        = hold_q;
    max_d         = max_q;
    time_d        = time_q;
    close         = 1'b0;
    close_timeout = 1'b0;
    close_len     = len_q;
    close_peak    = max_q;
    close_time    = time_q;

    if (valid_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (any_tot) begin
            max_d  = fold_val;
            time_d = fold_time;
            len_d  = 16'd1;
            if (MAX_LEN == 16'd1) begin
              // A one-cycle limit closes the window on the cycle it opens.
              close         = 1'b1;
              close_timeout = 1'b1;
              close_len     = 16'd1;
              close_peak    = fold_val;
              close_time    = fold_time;
              state_d       = S_WAIT_LOW;
            end else begin
              state_d = S_ACTIVE;
            end
          end
        end

        S_ACTIVE: begin
          if (any_tot) begin
            max_d  = fold_val;
            time_d = fold_time;
            len_d  = len_q + 16'd1;
            if (len_q + 16'd1 == MAX_LEN) begin
              close         = 1'b1;
              close_timeout = 1'b1;
              close_len     = len_q + 16'd1;
              close_peak    = fold_val;
              close_time    = fold_time;
              state_d       = S_WAIT_LOW;
            end
          end else begin
            // Natural end: this cycle's samples are outside the window.
            close   = 1'b1;
            hold_d  = '0;
            state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
          end
        end

        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_IDLE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        S_WAIT_LOW: begin
          // The cycle that sees tot fall is not part of the holdoff count.
          if (!any_tot) begin
            hold_d  = '0;
            state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Window tracking state. A reset here also aborts any open window.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cycle_cnt <= '0;
      len_q     <= '0;
      hold_q    <= '0;
      max_q     <= '0;
      time_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      max_q   <= max_d;
      time_q  <= time_d;
      if (valid_in) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

  // One-deep result register. A close that arrives while an unconsumed result
  // is held is discarded; a close coinciding with consumption replaces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      peak      <= '0;
      peak_time <= '0;
      trig_len  <= '0;
      timeout   <= 1'b0;
    end else if (close && (!valid_out || ready_in)) begin
      valid_out <= 1'b1;
      peak      <= close_peak;
      peak_time <= close_time;
      trig_len  <= close_len;
      timeout   <= close_timeout;
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

`ifdef FIR_PEAK_FINDER_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (close && valid_out && !ready_in && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fir_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_fir_peak_finder
//
// Self-checking bench for fir_peak_finder with default parameters
// (MAX_TRIG_LEN=64, HOLDOFF=4, TIME_W=32). Expected results are pushed to a
// scoreboard queue when a close is driven and popped by a monitor whenever the
// DUT hands over a result (valid_out && ready_in). Window vectors come from a
// table; holdoff re-arm, timeout, back-pressure, valid gaps and mid-window
// reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fir_peak_finder;

  localparam int MAX_TRIG_LEN = 64;
  localparam int HOLDOFF      = 4;
  localparam int TIME_W       = 32;
  localparam logic [30:0] BIG = 31'h7FFF_FFFF;

`ifdef FIR_PEAK_FINDER_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd2;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  logic              clk;
  logic              reset_n;
  logic              valid_in;
  logic [30:0]       fout_0, fout_1, fout_2, fout_3;
  logic              tot_0, tot_1, tot_2, tot_3;
  logic              valid_out;
  logic              ready_in;
  logic [30:0]       peak;
  logic [TIME_W-1:0] peak_time;
  logic [15:0]       trig_len;
  logic              timeout;
  logic [7:0]        drop_count;

  fir_peak_finder #(
    .MAX_TRIG_LEN (MAX_TRIG_LEN),
    .HOLDOFF      (HOLDOFF),
    .TIME_W       (TIME_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_in   (valid_in),
    .fout_0     (fout_0),
    .fout_1     (fout_1),
    .fout_2     (fout_2),
    .fout_3     (fout_3),
    .tot_0      (tot_0),
    .tot_1      (tot_1),
    .tot_2      (tot_2),
    .tot_3      (tot_3),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .peak       (peak),
    .peak_time  (peak_time),
    .trig_len   (trig_len),
    .timeout    (timeout),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0]       peak;
    logic [TIME_W-1:0] peak_time;
    logic [15:0]       trig_len;
    logic              timeout;
  } res_t;

  typedef struct {
    int          len;
    int          pk_cyc;
    int          pk_lane;
    logic [30:0] pk_val;
    int          tie_cyc;
    int          tie_lane;
    logic [3:0]  tot_pat;
  } vec_t;

  res_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;  // bench's own count of valid cycles since reset

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [30:0] p, input int t, input int l, input logic to);
    res_t r;
    r.peak      = p;
    r.peak_time = TIME_W'(t);
    r.trig_len  = 16'(l);
    r.timeout   = to;
    sb.push_back(r);
  endtask

  task automatic step(input logic v, input logic [3:0] t,
                      input logic [30:0] s0, input logic [30:0] s1,
                      input logic [30:0] s2, input logic [30:0] s3);
    valid_in = v;
    {tot_3, tot_2, tot_1, tot_0} = t;
    fout_0 = s0;
    fout_1 = s1;
    fout_2 = s2;
    fout_3 = s3;
    @(posedge clk);
    #1;
    if (v) cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 4'b0000, 31'd0, 31'd0, 31'd0, 31'd0);
  endtask

  // Monitor: a handshake completes at the coming edge whenever valid_out and
  // ready_in are both high mid-cycle.
  always @(negedge clk) begin
    if (reset_n && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {63'd0, valid_out}, 64'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("peak",      {33'd0, peak},      {33'd0, e.peak});
        check("peak_time", {32'd0, peak_time}, {32'd0, e.peak_time});
        check("trig_len",  {48'd0, trig_len},  {48'd0, e.trig_len});
        check("timeout",   {63'd0, timeout},   {63'd0, e.timeout});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [6];
    logic [30:0] s [4];
    int          start;

    // len, pk_cyc, pk_lane, pk_val, tie_cyc, tie_lane, tot pattern
    vecs[0] = '{3, 1, 2, 31'd5000,       -1, -1, 4'b0001};  // pulse at cycle 10
    vecs[1] = '{2, 0, 1, 31'd700,         0,  3, 4'b0010};  // in-cycle tie
    vecs[2] = '{4, 1, 2, 31'd900,         2,  0, 4'b0100};  // cross-cycle tie
    vecs[3] = '{1, 0, 0, 31'd1234,       -1, -1, 4'b1000};  // one-cycle window
    vecs[4] = '{5, 4, 3, 31'h7FFF_FFFE,  -1, -1, 4'b1111};  // peak on last cycle
    vecs[5] = '{3, 0, 0, 31'd2000,        2,  3, 4'b0011};  // seed lane wins tie

    reset_n  = 1'b0;
    ready_in = 1'b1;
    valid_in = 1'b0;
    {tot_3, tot_2, tot_1, tot_0} = 4'b0000;
    fout_0 = '0; fout_1 = '0; fout_2 = '0; fout_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out",  {63'd0, valid_out},  64'd0);
    check("rst_peak",       {33'd0, peak},       64'd0);
    check("rst_peak_time",  {32'd0, peak_time},  64'd0);
    check("rst_trig_len",   {48'd0, trig_len},   64'd0);
    check("rst_timeout",    {63'd0, timeout},    64'd0);
    check("rst_drop_count", {56'd0, drop_count}, 64'd0);
    reset_n = 1'b1;
    cyc     = 0;

    // Bring cycle_cnt to 10 so the first window starts there.
    idle(10);

    // Table-driven windows. The closing cycle carries maximal samples that
    // must stay outside the window.
    for (int v = 0; v < 6; v++) begin
      start = cyc;
      for (int c = 0; c < vecs[v].len; c++) begin
        for (int l = 0; l < 4; l++) begin
          if ((c == vecs[v].pk_cyc && l == vecs[v].pk_lane) ||
              (c == vecs[v].tie_cyc && l == vecs[v].tie_lane))
            s[l] = vecs[v].pk_val;
          else
            s[l] = 31'(100 + c * 4 + l);
        end
        step(1'b1, vecs[v].tot_pat, s[0], s[1], s[2], s[3]);
      end
      push(vecs[v].pk_val, (start + vecs[v].pk_cyc) * 4 + vecs[v].pk_lane, vecs[v].len, 1'b0);
      step(1'b1, 4'b0000, BIG, BIG, BIG, BIG);
      check("close_latency", {63'd0, valid_out}, 64'd1);
      idle(HOLDOFF + 1);
    end

    // Re-arm: tot held through holdoff is ignored; the new window opens
    // exactly HOLDOFF+1 valid cycles after the close.
    start = cyc;
    for (int c = 0; c < 2; c++)
      step(1'b1, 4'b0001, 31'(100 + c * 4), 31'(101 + c * 4), 31'(102 + c * 4), 31'(103 + c * 4));
    push(31'd107, (start + 1) * 4 + 3, 2, 1'b0);
    step(1'b1, 4'b0000, 31'd0, 31'd0, 31'd0, 31'd0);
    repeat (HOLDOFF) step(1'b1, 4'b1111, 31'h7FFF_0000, 31'h7FFF_0000, 31'h7FFF_0000, 31'h7FFF_0000);
    start = cyc;
    for (int c = 0; c < 3; c++)
      step(1'b1, 4'b0001, 31'(50 + c * 4), 31'(51 + c * 4), 31'(52 + c * 4), 31'(53 + c * 4));
    push(31'd61, (start + 2) * 4 + 3, 3, 1'b0);
    step(1'b1, 4'b0000, BIG, BIG, BIG, BIG);
    idle(HOLDOFF + 1);

    // valid_in gaps: invalid cycles carry tot low and huge samples, both of
    // which must be ignored; timestamps count valid cycles only.
    start = cyc;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0000, BIG, BIG, BIG, BIG);
      step(1'b1, 4'b0001, (k == 2) ? 31'd4000 : 31'(300 + k), 31'd1, 31'd2, 31'd3);
    end
    step(1'b0, 4'b0000, BIG, BIG, BIG, BIG);
    push(31'd4000, (start + 2) * 4, 4, 1'b0);
    step(1'b1, 4'b0000, BIG, BIG, BIG, BIG);
    idle(HOLDOFF + 1);

    // Stuck tot: forced close at 64 cycles, then no new window until tot
    // falls and holdoff expires.
    start = cyc;
    for (int c = 0; c < 80; c++) begin
      if (c == MAX_TRIG_LEN - 1)
        push(31'(1000 + c * 4 + 3), (start + c) * 4 + 3, MAX_TRIG_LEN, 1'b1);
      step(1'b1, 4'b1111, 31'(1000 + c * 4), 31'(1001 + c * 4), 31'(1002 + c * 4), 31'(1003 + c * 4));
    end
    step(1'b1, 4'b0000, BIG, BIG, BIG, BIG);
    repeat (HOLDOFF) step(1'b1, 4'b0100, BIG, BIG, BIG, BIG);
    start = cyc;
    for (int c = 0; c < 2; c++)
      step(1'b1, 4'b0100, 31'(20 + c * 4), 31'(21 + c * 4), 31'(22 + c * 4), 31'(23 + c * 4));
    push(31'd27, (start + 1) * 4 + 3, 2, 1'b0);
    step(1'b1, 4'b0000, BIG, BIG, BIG, BIG);
    idle(HOLDOFF + 1);
    check("sb_drained_before_backpressure", 64'(sb.size()), 64'd0);

    // Back-pressure: three closes with ready_in low keep only the first.
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start = cyc;
      if (k == 0) push(31'd111, start * 4, 1, 1'b0);
      step(1'b1, 4'b0001, 31'(111 * (k + 1)), 31'd0, 31'd0, 31'd0);
      step(1'b1, 4'b0000, 31'd0, 31'd0, 31'd0, 31'd0);
      idle(HOLDOFF + 1);
    end
    check("held_valid_out", {63'd0, valid_out},  64'd1);
    check("held_peak",      {33'd0, peak},       64'd111);
    check("drop_count",     {56'd0, drop_count}, {56'd0, EXP_DROP});
    ready_in = 1'b1;
    step(1'b0, 4'b0000, 31'd0, 31'd0, 31'd0, 31'd0);
    check("valid_out_after_ready", {63'd0, valid_out}, 64'd0);

    // Mid-window reset: outputs clear and the aborted window never reports.
    step(1'b1, 4'b0010, 31'd900, 31'd901, 31'd902, 31'd903);
    step(1'b1, 4'b0010, 31'd910, 31'd911, 31'd912, 31'd913);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid_out",  {63'd0, valid_out},  64'd0);
    check("mid_rst_peak",       {33'd0, peak},       64'd0);
    check("mid_rst_peak_time",  {32'd0, peak_time},  64'd0);
    check("mid_rst_trig_len",   {48'd0, trig_len},   64'd0);
    check("mid_rst_timeout",    {63'd0, timeout},    64'd0);
    check("mid_rst_drop_count", {56'd0, drop_count}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    idle(HOLDOFF + 3);
    check("no_result_after_reset", {63'd0, valid_out}, 64'd0);

    idle(3);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
